logic8_bist_analyzer: RTL and testbench
=======================================

# logic8_bist_analyzer

Response-side BIST block for the 8-bit bitwise logic units (OR/AND/XOR) of the ALU datapath. It accepts a stream of 8-bit unit results over a valid/ready handshake and compacts them into a 16-bit MISR signature. After a programmed number of samples, it compares the signature against a golden value and reports pass/fail. It sits between the unit-under-test output and the ALU self-test status register.

## Interface
- NUM_SAMPLES, 256: results compacted per run; legal range is 1 to 65535.
- SEED, 16'hFFFF: MISR value loaded on reset and on each accepted start.
- GOLDEN, 16'h0000: expected final signature.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request.
- o_in  in  8  result byte from the unit under test.
- in_valid  in  1  o_in is valid this cycle.
- in_ready  out  1  analyzer accepts o_in this cycle.
- busy  out  1  run in progress (RUN or CHECK).
- done  out  1  run finished; pass is valid.
- pass  out  1  final signature == GOLDEN.
- signature  out  16  current MISR contents.

## Operation
- States:
  - IDLE: in_ready=0. start → load SEED, clear count, go to RUN.
  - RUN: in_ready=1. Each beat with in_valid&&in_ready updates the MISR and increments count. The accept that brings count to NUM_SAMPLES goes to CHECK.
  - CHECK: one cycle. in_ready=0. Register pass = (signature==GOLDEN), set done, go to DONE.
  - DONE: done and pass held. start → same as start in IDLE (done/pass cleared, SEED loaded).
- start in RUN or CHECK is ignored.
- MISR update on accept: next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {8'h00, o_in}.
- No update occurs without an accept. o_in is ignored when in_ready=0.
- count is 16 bits and never wraps: it saturates at NUM_SAMPLES via the transition to CHECK.
- busy = (state==RUN)||(state==CHECK).

## Timing
- Reset values: state=IDLE, signature=SEED, count=0, in_ready=0, busy=0, done=0, pass=0.
- rst takes effect immediately at assertion, including mid-run; the partial signature is discarded.
- start sampled at edge t → RUN visible and in_ready=1 from t+1.
- Accept at edge t → signature updated, visible at t+1.
- Last accept at edge k → CHECK during k+1 (busy=1, in_ready=0) → done=1 and pass valid from k+2.
- in_ready depends only on state, never on in_valid, so there is no combinational path from in_valid to in_ready.
- Zero-bubble throughput: one accept per cycle while in_valid stays high.
- Restart from DONE: start at edge t → done=0, pass=0, signature=SEED visible at t+1.

## Structure
- Package logic8_bist_pkg holds:
  - state typedef (IDLE, RUN, CHECK, DONE);
  - MISR_POLY = 16'h1021;
  - function misr_next(sig, din).
- Sub-module misr16: 16-bit register with load (SEED) and enable (accept). The top-level FSM and counter instantiate it once.

## Test plan
- Reset check: assert rst mid-run after 3 accepts → all outputs return to reset values immediately; signature=16'hFFFF.
- Single sample, NUM_SAMPLES=1, SEED=FFFF, o_in=8'h00 → signature=16'hEFDF; done rises 2 cycles after the accept. With GOLDEN=EFDF, pass=1.
- Same setup with o_in=8'hA5 → signature=16'hEF7A. With GOLDEN=EFDF, pass=0.
- Two samples, NUM_SAMPLES=2, o_in=8'h00 twice, with in_valid low for 3 cycles between them:
  - signature EFDF then CF9F;
  - no update during the gap;
  - in_ready stays 1 until the second accept.
- Back-to-back run, NUM_SAMPLES=256: drive o_in = a|b with a=i, b=~i for i=0..255 (all 8'hFF); compare against the bench model's signature.
  - busy=1 for exactly 257 cycles;
  - start pulses during RUN are ignored.
- Restart from DONE: start → done/pass clear next cycle, signature=FFFF. A second identical run reproduces an identical signature and pass.

Source files
------------

// File: rtl/logic8_bist_pkg.sv
// Shared types, constants and MISR step function for the 8-bit logic-unit
// response analyzer.
package logic8_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    // One MISR compaction step: shift left, fold the feedback polynomial in
    // when the bit shifted out is set, then inject the 8-bit result byte.
    function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                              input logic [7:0]  din);
        logic [15:0] fb;
        fb = sig[15] ? MISR_POLY : 16'h0000;
        return {sig[14:0], 1'b0} ^ fb ^ {8'h00, din};
    endfunction

endpackage

// File: rtl/logic8_bist_analyzer_misr16.sv
// 16-bit multiple-input signature register: loads SEED on reset or load,
// compacts one byte per enabled cycle, otherwise holds.
module misr16 #(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [7:0]  din,
    output logic [15:0] sig
);
    import logic8_bist_pkg::*;

    // Signature register: seed takes priority over compaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (enable) begin
            sig <= misr_next(sig, din);
        end else begin
            sig <= sig;
        end
    end

endmodule

// File: rtl/logic8_bist_analyzer.sv
// Response-side BIST analyzer: compacts NUM_SAMPLES result bytes into a MISR
// signature and compares it with GOLDEN at the end of each run.
module logic8_bist_analyzer #(
    parameter int unsigned  NUM_SAMPLES = 256,
    parameter logic [15:0]  SEED        = 16'hFFFF,
    parameter logic [15:0]  GOLDEN      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  o_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);
    import logic8_bist_pkg::*;

    localparam logic [15:0] LAST_COUNT = 16'(NUM_SAMPLES);

    state_t      state_r;
    logic [15:0] count_r;
    logic        accept_s;
    logic        load_s;
    logic        last_s;

    // in_ready is a registered copy of (state == RUN), so the handshake has
    // no combinational path from in_valid back to in_ready.
    assign accept_s = in_valid && in_ready;
    assign load_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s   = (count_r + 16'd1) == LAST_COUNT;

    misr16 #(
        .SEED (SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .enable (accept_s),
        .din    (o_in),
        .sig    (signature)
    );

    // Run-control FSM with sample counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= 16'd0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        count_r  <= 16'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        count_r <= count_r + 16'd1;
                        if (last_s) begin
                            state_r  <= ST_CHECK;
                            in_ready <= 1'b0;
                        end else begin
                            state_r  <= ST_RUN;
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_CHECK: begin
                    // Signature already holds the final compaction here.
                    state_r <= ST_DONE;
                    pass    <= (signature == GOLDEN);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    count_r  <= 16'd0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic8_bist_analyzer.sv
// Self-checking bench for logic8_bist_analyzer: three instances cover the
// 1-, 2- and 256-sample configurations; expectations come from a GF(2)
// polynomial model of the signature.
module tb_logic8_bist_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  o_in;
    logic        in_valid;
    logic        start1, start2, start3;
    logic        in_ready1, busy1, done1, pass1;
    logic        in_ready2, busy2, done2, pass2;
    logic        in_ready3, busy3, done3, pass3;
    logic [15:0] sig1, sig2, sig3;

    int tests = 0;
    int fails = 0;

    localparam logic [15:0] GOLD3 = 16'h0000;

    always #5 clk = ~clk;

    logic8_bist_analyzer #(.NUM_SAMPLES(1), .SEED(16'hFFFF), .GOLDEN(16'hEFDF)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .o_in(o_in), .in_valid(in_valid),
        .in_ready(in_ready1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

    logic8_bist_analyzer #(.NUM_SAMPLES(2), .SEED(16'hFFFF), .GOLDEN(16'hCF9F)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .o_in(o_in), .in_valid(in_valid),
        .in_ready(in_ready2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

    logic8_bist_analyzer #(.NUM_SAMPLES(256), .SEED(16'hFFFF), .GOLDEN(GOLD3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .o_in(o_in), .in_valid(in_valid),
        .in_ready(in_ready3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

    // Signature as a polynomial: multiply by x modulo x^16+x^12+x^5+1, add the byte.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [7:0] d);
        int unsigned v;
        v = 32'(s) * 32'd2;
        if (v >= 32'd65536) v = v ^ 32'h0001_1021;
        return v[15:0] ^ {8'h00, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a full 256-sample run on dut3 and check it cycle by cycle.
    task automatic run256(input bit rnd, output logic [15:0] model, output int busy_cnt);
        int acc;
        bit acc_now;
        logic [7:0] a, b;
        model    = 16'hFFFF;
        busy_cnt = 0;
        acc      = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (busy3) busy_cnt++;
            if (done3) break;
            chk("run_in_ready", 32'(in_ready3), 32'(acc < 256));
            chk("run_sig", 32'(sig3), 32'(model));
            if (rnd) begin
                in_valid = 1'($urandom_range(0, 1));
                o_in     = 8'($urandom);
            end else begin
                a = 8'(acc);
                b = ~a;
                in_valid = (acc < 256);
                o_in     = a | b;
            end
            start3  = (c == 40) || (c == 150);
            acc_now = in_valid && (acc < 256);
            tick();
            start3 = 1'b0;
            if (acc_now) begin
                model = ref_step(model, o_in);
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("run_accepts", 32'(acc), 32'd256);
        chk("run_done", 32'(done3), 32'd1);
        chk("run_final_sig", 32'(sig3), 32'(model));
        chk("run_pass", 32'(pass3), 32'(model == GOLD3));
    endtask

    initial begin
        logic [15:0] m, m_first;
        int bc;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        in_valid = 1'b0; o_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig", 32'(sig3), 32'hFFFF);
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_ready", 32'(in_ready3), 32'd0);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_pass", 32'(pass3), 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-run after three accepts.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("mid_busy", 32'(busy3), 32'd1);
        m = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            o_in = 8'($urandom);
            tick();
            m = ref_step(m, o_in);
        end
        in_valid = 1'b0;
        chk("mid_sig", 32'(sig3), 32'(m));
        rst = 1'b1;
        #1;
        chk("mid_rst_sig", 32'(sig3), 32'hFFFF);
        chk("mid_rst_busy", 32'(busy3), 32'd0);
        chk("mid_rst_ready", 32'(in_ready3), 32'd0);
        chk("mid_rst_done", 32'(done3), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single sample 8'h00 -> EFDF, pass.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1_ready", 32'(in_ready1), 32'd1);
        in_valid = 1'b1; o_in = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("s1_sig", 32'(sig1), 32'hEFDF);
        chk("s1_check_busy", 32'(busy1), 32'd1);
        chk("s1_check_ready", 32'(in_ready1), 32'd0);
        chk("s1_check_done", 32'(done1), 32'd0);
        tick();
        chk("s1_done", 32'(done1), 32'd1);
        chk("s1_pass", 32'(pass1), 32'd1);
        chk("s1_idle_busy", 32'(busy1), 32'd0);

        // Restart from DONE, single sample 8'hA5 -> EF7A, fail.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("rs1_done", 32'(done1), 32'd0);
        chk("rs1_pass", 32'(pass1), 32'd0);
        chk("rs1_sig", 32'(sig1), 32'hFFFF);
        in_valid = 1'b1; o_in = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("a5_sig", 32'(sig1), 32'hEF7A);
        tick();
        chk("a5_done", 32'(done1), 32'd1);
        chk("a5_pass", 32'(pass1), 32'd0);

        // Two samples with a three-cycle gap.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        in_valid = 1'b1; o_in = 8'h00;
        tick();
        in_valid = 1'b0; o_in = 8'h5A;
        chk("s2_first", 32'(sig2), 32'hEFDF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_gap_sig", 32'(sig2), 32'hEFDF);
            chk("s2_gap_ready", 32'(in_ready2), 32'd1);
        end
        in_valid = 1'b1; o_in = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("s2_second", 32'(sig2), 32'hCF9F);
        chk("s2_ready_low", 32'(in_ready2), 32'd0);
        tick();
        chk("s2_done", 32'(done2), 32'd1);
        chk("s2_pass", 32'(pass2), 32'd1);

        // Back-to-back 256-sample run of a|~a, with ignored start pulses.
        run256(1'b0, m_first, bc);
        chk("b2b_busy_cycles", 32'(bc), 32'd257);

        // Restart from DONE and reproduce the identical run.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("rs3_done", 32'(done3), 32'd0);
        chk("rs3_pass", 32'(pass3), 32'd0);
        chk("rs3_sig", 32'(sig3), 32'hFFFF);
        tick();
        run256(1'b0, m, bc);
        chk("repeat_sig", 32'(sig3), 32'(m_first));
        chk("repeat_busy_cycles", 32'(bc), 32'd257);

        // Randomised data and valid gaps.
        for (int r = 0; r < 3; r++) begin
            run256(1'b1, m, bc);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
